// File: rtl/sd_adder_arbiter_pkg.sv
// Shared digit-format constants and types for the signed-digit adder arbiter.
// Build option: SDADD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package sd_arith_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_BITS = 3;
  localparam int RADIX      = 4;

  typedef logic req_id_t;

  // Requester 1 is marked as the previous winner so requester 0 wins first after reset.
  localparam req_id_t LAST_GRANT_RST = 1'b1;
endpackage

// File: rtl/sd_adder_arbiter_if.sv
// Request/response bundle between two digit pipelines and the shared adder arbiter.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface sd_adder_arbiter_if
  import sd_arith_pkg::*;
#(
  parameter int no_of_digits = NUM_DIGITS,
  parameter int radix_bits   = DIGIT_BITS
);
  logic                               req0_valid;
  logic                               req0_ready;
  logic [no_of_digits*radix_bits-1:0] req0_din1;
  logic [no_of_digits*radix_bits-1:0] req0_din2;
  logic [radix_bits-1:0]              req0_cin;

  logic                               req1_valid;
  logic                               req1_ready;
  logic [no_of_digits*radix_bits-1:0] req1_din1;
  logic [no_of_digits*radix_bits-1:0] req1_din2;
  logic [radix_bits-1:0]              req1_cin;

  logic                               rsp_valid;
  logic                               rsp_ready;
  req_id_t                            rsp_id;
  logic [no_of_digits*radix_bits-1:0] rsp_dout;
  logic [radix_bits-1:0]              rsp_cout;

  modport master (
    output req0_valid, req0_din1, req0_din2, req0_cin,
    output req1_valid, req1_din1, req1_din2, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_dout, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_din1, req0_din2, req0_cin,
    input  req1_valid, req1_din1, req1_din2, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_dout, rsp_cout
  );
endinterface

// File: rtl/sd_adder_arbiter_adder.sv
// Combinational radix-4 signed-digit adder: each digit sum is split into a transfer
// (-1/0/+1) to the next digit and a residual, then the incoming transfer is added.
module radix4adder_new #(
  parameter int no_of_digits = 8,
  parameter int radix_bits   = 3,
  parameter int radix        = 4
) (
  input  logic [no_of_digits*radix_bits-1:0] din1,
  input  logic [no_of_digits*radix_bits-1:0] din2,
  input  logic [radix_bits-1:0]              cin,
  output logic [no_of_digits*radix_bits-1:0] dout,
  output logic [radix_bits-1:0]              cout
);
  localparam int DW = no_of_digits * radix_bits;
  localparam int SW = radix_bits + 1;
  localparam logic signed [SW-1:0]   RAD_S = SW'(radix);
  localparam logic [radix_bits-1:0] RAD_D = radix_bits'(radix);

  logic [DW-1:0] xfer_out;
  logic [DW-1:0] xfer_in;

  // Digit i receives the transfer produced by digit i-1; digit 0 receives cin.
  assign xfer_in = {xfer_out[DW-radix_bits-1:0], cin};
  assign cout    = xfer_out[DW-1 -: radix_bits];

  for (genvar g = 0; g < no_of_digits; g++) begin : g_digit
    logic [radix_bits-1:0] a;
    logic [radix_bits-1:0] b;
    logic signed [SW-1:0]  s;
    logic                  pos;
    logic                  neg;

    assign a   = din1[g*radix_bits +: radix_bits];
    assign b   = din2[g*radix_bits +: radix_bits];
    assign s   = $signed({a[radix_bits-1], a}) + $signed({b[radix_bits-1], b});
    assign pos = (s >= RAD_S);
    assign neg = (s <= -RAD_S);

    assign xfer_out[g*radix_bits +: radix_bits] = pos ? radix_bits'(1) : (neg ? '1 : '0);
    // Out-of-range digits wrap; the adder deliberately does not saturate.
    assign dout[g*radix_bits +: radix_bits] = s[radix_bits-1:0]
                                            + xfer_in[g*radix_bits +: radix_bits]
                                            - (pos ? RAD_D : '0)
                                            + (neg ? RAD_D : '0);
  end
endmodule

// File: rtl/sd_adder_arbiter.sv
// Two-requester arbiter around one shared radix-4 signed-digit adder with a
// single-entry registered response slot. Build option: SDADD_ARB_FIXED_PRIO_EN.
module sd_adder_arbiter
  import sd_arith_pkg::*;
#(
  parameter int no_of_digits = NUM_DIGITS,
  parameter int radix_bits   = DIGIT_BITS,
  parameter int radix        = RADIX
) (
  input logic               clk,
  input logic               rst,
  sd_adder_arbiter_if.slave bus
);
  localparam int DW = no_of_digits * radix_bits;

  logic                  slot_free;
  logic                  grant_valid;
  logic                  accept;
  req_id_t               grant;
  logic [DW-1:0]         op_a;
  logic [DW-1:0]         op_b;
  logic [radix_bits-1:0] op_c;
  logic [DW-1:0]         sum;
  logic [radix_bits-1:0] carry;

  logic                  rsp_valid_q, rsp_valid_d;
  req_id_t               rsp_id_q, rsp_id_d;
  logic [DW-1:0]         rsp_dout_q, rsp_dout_d;
  logic [radix_bits-1:0] rsp_cout_q, rsp_cout_d;

  assign slot_free   = !rsp_valid_q || bus.rsp_ready;
  assign grant_valid = bus.req0_valid || bus.req1_valid;
  assign accept      = !rst && slot_free && grant_valid;

`ifdef SDADD_ARB_FIXED_PRIO_EN
  assign grant = bus.req0_valid ? 1'b0 : 1'b1;
`else
  req_id_t last_grant_q, last_grant_d;

  // On a collision the requester that did not win last time is served.
  always_comb begin
    grant = bus.req0_valid ? 1'b0 : 1'b1;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
  end

  assign last_grant_d = accept ? grant : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= LAST_GRANT_RST;
    else     last_grant_q <= last_grant_d;
  end
`endif

  assign bus.req0_ready = accept && (grant == 1'b0);
  assign bus.req1_ready = accept && (grant == 1'b1);

  assign op_a = grant ? bus.req1_din1 : bus.req0_din1;
  assign op_b = grant ? bus.req1_din2 : bus.req0_din2;
  assign op_c = grant ? bus.req1_cin  : bus.req0_cin;

  radix4adder_new #(
    .no_of_digits(no_of_digits),
    .radix_bits  (radix_bits),
    .radix       (radix)
  ) u_adder (
    .din1(op_a),
    .din2(op_b),
    .cin (op_c),
    .dout(sum),
    .cout(carry)
  );

  // The slot refills in the same cycle it drains, so a stalled consumer only
  // blocks new grants while the slot is full.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_dout_d  = rsp_dout_q;
    rsp_cout_d  = rsp_cout_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant;
      rsp_dout_d  = sum;
      rsp_cout_d  = carry;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_dout_q  <= '0;
      rsp_cout_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dout_q  <= rsp_dout_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_dout  = rsp_dout_q;
  assign bus.rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_sd_adder_arbiter.sv
// Self-checking bench for sd_adder_arbiter: directed vector table plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_sd_adder_arbiter;
  import sd_arith_pkg::*;

  localparam int DW = NUM_DIGITS * DIGIT_BITS;
`ifdef SDADD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [DW-1:0] Z  = '0;
  localparam logic [DW-1:0] A1 = {8{3'b001}};
  localparam logic [DW-1:0] S2 = {8{3'b010}};
  localparam logic [DW-1:0] A3 = {8{3'b011}};
  localparam logic [DW-1:0] S3 = {{7{3'b011}}, 3'b010};
  localparam logic [DW-1:0] N3 = {8{3'b101}};
  localparam logic [2:0]    C0 = 3'b000;
  localparam logic [2:0]    C1 = 3'b001;
  localparam logic [2:0]    CM = 3'b111;

  typedef struct {
    logic          rst, v0, v1;
    logic [DW-1:0] a0, b0;
    logic [2:0]    c0;
    logic [DW-1:0] a1, b1;
    logic [2:0]    c1;
    logic          rdy;
    logic          er0, er1;
    logic          ev, eid;
    logic [DW-1:0] ed;
    logic [2:0]    ec;
  } vec_t;

  logic clk;
  logic rst;
  sd_adder_arbiter_if bus ();

  sd_adder_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          m_valid, m_id, m_last;
  logic [DW-1:0] m_dout;
  logic [2:0]    m_cout;
  logic          acc0, acc1;
  vec_t          tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference sum computed from the digit rule with plain integers.
  function automatic void refSum(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] c,
                                 output logic [DW-1:0] d, output logic [2:0] co);
    logic signed [2:0] da, db, dc;
    logic [31:0]       dv;
    int                t, tn, s, w;
    dc = c;
    t  = int'(dc);
    d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      da = a[i*3 +: 3];
      db = b[i*3 +: 3];
      s  = int'(da) + int'(db);
      if (s >= RADIX)       begin w = s - RADIX; tn = 1;  end
      else if (s <= -RADIX) begin w = s + RADIX; tn = -1; end
      else                  begin w = s;         tn = 0;  end
      dv = 32'(w + t);
      d[i*3 +: 3] = dv[2:0];
      t = tn;
    end
    dv = 32'(t);
    co = dv[2:0];
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    bus.req0_valid = v.v0;
    bus.req0_din1  = v.a0;
    bus.req0_din2  = v.b0;
    bus.req0_cin   = v.c0;
    bus.req1_valid = v.v1;
    bus.req1_din1  = v.a1;
    bus.req1_din2  = v.b1;
    bus.req1_cin   = v.c1;
    bus.rsp_ready  = v.rdy;
    #4;
  endtask

  // Compares this cycle against the model, advances the model, and moves to posedge+1.
  task automatic checkOutput(input string tag);
    logic          free, winner, anyreq, er0, er1;
    logic [DW-1:0] nd;
    logic [2:0]    nc;
    er0 = 1'b0; er1 = 1'b0; winner = 1'b0;
    if (!rst) begin
      free   = !m_valid || bus.rsp_ready;
      anyreq = bus.req0_valid || bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) winner = FIXED ? 1'b0 : !m_last;
      else if (bus.req1_valid)              winner = 1'b1;
      er0 = free && anyreq && !winner;
      er1 = free && anyreq && winner;
    end
    chk({tag, ".req0_ready"}, 32'(bus.req0_ready), 32'(er0));
    chk({tag, ".req1_ready"}, 32'(bus.req1_ready), 32'(er1));
    chk({tag, ".rsp_valid"},  32'(bus.rsp_valid),  32'(m_valid));
    chk({tag, ".rsp_id"},     32'(bus.rsp_id),     32'(m_id));
    chk({tag, ".rsp_dout"},   32'(bus.rsp_dout),   32'(m_dout));
    chk({tag, ".rsp_cout"},   32'(bus.rsp_cout),   32'(m_cout));
    acc0 = er0 && bus.req0_valid;
    acc1 = er1 && bus.req1_valid;
    if (rst) begin
      m_valid = 1'b0; m_id = 1'b0; m_dout = '0; m_cout = '0; m_last = LAST_GRANT_RST;
    end else if (acc0 || acc1) begin
      if (acc1) refSum(bus.req1_din1, bus.req1_din2, bus.req1_cin, nd, nc);
      else      refSum(bus.req0_din1, bus.req0_din2, bus.req0_cin, nd, nc);
      m_valid = 1'b1; m_id = acc1; m_dout = nd; m_cout = nc; m_last = acc1;
    end else if (bus.rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t cur;
    cur = '{default: '0};
    cur.rst = 1'b1;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_din1 = '0; bus.req0_din2 = '0; bus.req0_cin = '0;
    bus.req1_valid = 1'b0; bus.req1_din1 = '0; bus.req1_din2 = '0; bus.req1_cin = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 1'b0; m_id = 1'b0; m_dout = '0; m_cout = '0; m_last = LAST_GRANT_RST;
    acc0 = 1'b0; acc1 = 1'b0;

`ifndef SDADD_ARB_FIXED_PRIO_EN
    //            rst   v0    v1    a0 b0 c0  a1 b1 c1  rdy   er0   er1   ev    eid   ed  ec
    tbl.push_back('{1'b0, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Z,  C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, S2, C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, S2, C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, S2, C0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, A3, A3, C0, Z,  Z,  C0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, S2, C0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,  Z,  C0, Z,  Z,  C0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, S3, C1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,  Z,  C0, Z,  Z,  C0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S3, C1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, N3, N3, CM, A1, A1, C0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S3, C1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, N3, N3, CM, A3, A3, C0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S2, C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, N3, N3, CM, A3, A3, C0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S2, C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, N3, N3, CM, A3, A3, C0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S2, C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, N3, N3, CM, A3, A3, C0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, S2, C0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, Z,  Z,  C0, A3, A3, C0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, N3, CM});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z,  Z,  C0, Z,  Z,  C0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S3, C1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S3, C1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S2, C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Z,  C0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, A1, A1, C0, A1, A1, C0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, S2, C0});

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      applyStimulus(tbl[i]);
      chk({tag, ".ready0"}, 32'(bus.req0_ready), 32'(tbl[i].er0));
      chk({tag, ".ready1"}, 32'(bus.req1_ready), 32'(tbl[i].er1));
      chk({tag, ".valid"},  32'(bus.rsp_valid),  32'(tbl[i].ev));
      chk({tag, ".id"},     32'(bus.rsp_id),     32'(tbl[i].eid));
      chk({tag, ".dout"},   32'(bus.rsp_dout),   32'(tbl[i].ed));
      chk({tag, ".cout"},   32'(bus.rsp_cout),   32'(tbl[i].ec));
      checkOutput(tag);
      cur = tbl[i];
    end
`else
    // Fixed priority: req0 wins four collisions in a row, req1 only once req0 drops.
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = '{1'b0, (i < 4), 1'b1, A1, A1, C0, A3, A3, C0, 1'b1, (i < 4), (i == 4), 1'b0, 1'b0, Z, C0};
      applyStimulus(v);
      chk($sformatf("fixed%0d.ready0", i), 32'(bus.req0_ready), 32'(v.er0));
      chk($sformatf("fixed%0d.ready1", i), 32'(bus.req1_ready), 32'(v.er1));
      checkOutput($sformatf("fixed%0d", i));
      cur = v;
    end
`endif

    // Random traffic; a request that was not accepted is held unchanged.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = cur;
      v.rst = ($urandom_range(0, 39) == 0);
      v.rdy = ($urandom_range(0, 3) != 0);
      if (!cur.v0 || acc0) begin
        v.v0 = 1'($urandom_range(0, 1));
        v.a0 = DW'($urandom);
        v.b0 = DW'($urandom);
        v.c0 = 3'($urandom);
      end
      if (!cur.v1 || acc1) begin
        v.v1 = 1'($urandom_range(0, 1));
        v.a1 = DW'($urandom);
        v.b1 = DW'($urandom);
        v.c1 = 3'($urandom);
      end
      applyStimulus(v);
      checkOutput($sformatf("rnd%0d", n));
      cur = v;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
